// File: rtl/bus_master_req_queue_if.sv
// Bus master request queue interface.
// Groups the request-source handshake, the host-side issue bus and the
// response channel. The "master" modport is the queue itself; the "slave"
// modport is the environment (request sources, host and response sink).
interface bus_master_req_queue_if #(
    parameter int MASTER_COUNT = 3,
    parameter int SLAVE_COUNT  = 4
);
    localparam int SW = $clog2(SLAVE_COUNT);
    localparam int MW = $clog2(MASTER_COUNT);

    // Request sources
    logic [MASTER_COUNT-1:0]    req_valid;
    logic [MASTER_COUNT-1:0]    req_ready;
    logic [32*MASTER_COUNT-1:0] req_addr;
    logic [32*MASTER_COUNT-1:0] req_data;
    logic [SW*MASTER_COUNT-1:0] req_sel;

    // Host issue bus
    logic [31:0]   master_addr;
    logic [31:0]   master_data;
    logic          master_req;
    logic [SW-1:0] slave_sel;
    logic [31:0]   slave_data;
    logic          bus_ack;
    logic          bus_err;

    // Responses
    logic          rsp_valid;
    logic [MW-1:0] rsp_master;
    logic [31:0]   rsp_data;
    logic          rsp_err;

    modport master (
        input  req_valid, req_addr, req_data, req_sel,
        input  slave_data, bus_ack, bus_err,
        output req_ready,
        output master_addr, master_data, master_req, slave_sel,
        output rsp_valid, rsp_master, rsp_data, rsp_err
    );

    modport slave (
        output req_valid, req_addr, req_data, req_sel,
        output slave_data, bus_ack, bus_err,
        input  req_ready,
        input  master_addr, master_data, master_req, slave_sel,
        input  rsp_valid, rsp_master, rsp_data, rsp_err
    );
endinterface

// File: rtl/bus_master_req_queue.sv
// Bus master request queue.
// Round-robin arbitration of MASTER_COUNT request sources into a request
// FIFO, then one-at-a-time issue to the host with retry on bus_err and one
// tagged response per request.
// Optional feature macro: BUS_TIMEOUT_EN -- when defined, a WAIT-state
// watchdog ends a silent transfer with an error response after
// TIMEOUT_CYCLES cycles; when undefined, WAIT waits indefinitely.
module bus_master_req_queue #(
    parameter int MASTER_COUNT   = 3,
    parameter int SLAVE_COUNT    = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int MAX_RETRY      = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    bus_master_req_queue_if.master      bus,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int SW = $clog2(SLAVE_COUNT);
    localparam int MW = $clog2(MASTER_COUNT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    // Elaboration-time parameter legality
    if (MASTER_COUNT < 2) begin : g_bad_master_count
        $error("MASTER_COUNT must be >= 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if (MAX_RETRY < 0 || MAX_RETRY > 7) begin : g_bad_max_retry
        $error("MAX_RETRY must be in 0..7");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    typedef struct packed {
        logic [MW-1:0] id;
        logic [31:0]   addr;
        logic [31:0]   data;
        logic [SW-1:0] sel;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    // Arbiter
    logic [MW-1:0] rr_ptr;      // first master searched on the next grant
    logic [MW-1:0] grant_id;
    logic [MW-1:0] cand;
    logic          grant_found;
    int            search_idx;

    // FIFO
    entry_t        fifo_mem [FIFO_DEPTH];
    entry_t        push_entry;
    entry_t        head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;

    // Issue FSM
    state_t        state;
    logic [2:0]    retry_cnt;
    logic [MW-1:0] hold_id;

`ifdef BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
`endif

    assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign push       = grant_found && !fifo_full;
    assign pop        = (state == S_IDLE) && !fifo_empty;
    assign head       = fifo_mem[rd_ptr];

    // Round-robin search for the first valid master starting at rr_ptr.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write,
        // otherwise unassigned paths would infer latches.
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        search_idx  = 0;
        for (int i = 0; i < MASTER_COUNT; i++) begin
            search_idx = int'(rr_ptr) + i;
            if (search_idx >= MASTER_COUNT) begin
                search_idx = search_idx - MASTER_COUNT;
            end
            cand = MW'(search_idx);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    // One-hot grant, suppressed while the FIFO is full.
    always_comb begin
        bus.req_ready = '0;
        if (push) begin
            bus.req_ready[grant_id] = 1'b1;
        end
        push_entry.id   = grant_id;
        push_entry.addr = bus.req_addr[32*int'(grant_id) +: 32];
        push_entry.data = bus.req_data[32*int'(grant_id) +: 32];
        push_entry.sel  = bus.req_sel[SW*int'(grant_id) +: SW];
    end

    // Round-robin pointer advances past the granted master on a handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (push) begin
            rr_ptr <= (int'(grant_id) == MASTER_COUNT - 1) ? '0 : grant_id + 1'b1;
        end
    end

    // FIFO storage: written on the grant edge.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; occupancy and pointers are, so stale
        // entries are never read.
        if (push) begin
            fifo_mem[wr_ptr] <= push_entry;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Issue FSM with registered host-bus and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            retry_cnt       <= '0;
            hold_id         <= '0;
            bus.master_req  <= 1'b0;
            bus.master_addr <= '0;
            bus.master_data <= '0;
            bus.slave_sel   <= '0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_master  <= '0;
            bus.rsp_data    <= '0;
            bus.rsp_err     <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            tmo_cnt         <= '0;
`endif
        end else begin
            bus.master_req <= 1'b0;
            bus.rsp_valid  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        hold_id         <= head.id;
                        bus.master_addr <= head.addr;
                        bus.master_data <= head.data;
                        bus.slave_sel   <= head.sel;
                        retry_cnt       <= '0;
                        bus.master_req  <= 1'b1;
                        state           <= S_REQ;
                    end
                end
                S_REQ: begin
`ifdef BUS_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    // Error takes priority over a coincident acknowledge.
                    if (bus.bus_err) begin
                        if (retry_cnt < 3'(MAX_RETRY)) begin
                            retry_cnt      <= retry_cnt + 1'b1;
                            bus.master_req <= 1'b1;
                            state          <= S_REQ;
                        end else begin
                            bus.rsp_valid  <= 1'b1;
                            bus.rsp_master <= hold_id;
                            bus.rsp_data   <= '0;
                            bus.rsp_err    <= 1'b1;
                            state          <= S_RESP;
                        end
                    end else if (bus.bus_ack) begin
                        bus.rsp_valid  <= 1'b1;
                        bus.rsp_master <= hold_id;
                        bus.rsp_data   <= bus.slave_data;
                        bus.rsp_err    <= 1'b0;
                        state          <= S_RESP;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        bus.rsp_valid  <= 1'b1;
                        bus.rsp_master <= hold_id;
                        bus.rsp_data   <= '0;
                        bus.rsp_err    <= 1'b1;
                        state          <= S_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_master_req_queue.sv
// Directed self-checking bench for bus_master_req_queue (default parameters:
// 3 masters, 4 slaves, 4-entry FIFO, 2 retries). Inputs change and outputs
// are sampled on the falling clock edge.
module tb_bus_master_req_queue;
    localparam int M = 3;
    localparam int S = 4;
    localparam int D = 4;
    localparam int R = 2;
    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] fifo_count;

    int checks = 0;
    int failures = 0;
    int req_pulses = 0;
    int rsp_pulses = 0;
    int max_count = 0;
    int base_req;
    int base_rsp;

    logic [2:0] exp_ready [7];
    int         exp_count [7];
    int         exp_m [5];

    bus_master_req_queue_if #(.MASTER_COUNT(M), .SLAVE_COUNT(S)) bus ();

    bus_master_req_queue #(
        .MASTER_COUNT(M), .SLAVE_COUNT(S), .FIFO_DEPTH(D),
        .MAX_RETRY(R), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Count issue and response pulses and track peak occupancy.
    always @(negedge clk) begin
        if (bus.master_req === 1'b1) req_pulses++;
        if (bus.rsp_valid === 1'b1) rsp_pulses++;
        if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "simulation watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.req_valid  = '0;
        bus.req_addr   = '0;
        bus.req_data   = '0;
        bus.req_sel    = '0;
        bus.slave_data = '0;
        bus.bus_ack    = 1'b0;
        bus.bus_err    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load(input int m, input logic [31:0] addr, input logic [31:0] data,
                        input logic [1:0] sel);
        bus.req_addr[32*m +: 32] = addr;
        bus.req_data[32*m +: 32] = data;
        bus.req_sel[2*m +: 2]    = sel;
    endtask

    // Wait (bounded) for a master_req pulse, starting with the current cycle.
    task automatic wait_req(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.master_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_req_seen"}, 32'(seen), 32'd1);
    endtask

    // Host answers on the next cycle (first WAIT cycle) for one cycle.
    task automatic host_reply(input string tag, input logic ack, input logic err,
                              input logic [31:0] data);
        @(negedge clk);
        check({tag, "_req_width"}, 32'(bus.master_req), 32'd0);
        bus.bus_ack    = ack;
        bus.bus_err    = err;
        bus.slave_data = data;
        @(negedge clk);
        bus.bus_ack    = 1'b0;
        bus.bus_err    = 1'b0;
        bus.slave_data = '0;
    endtask

    initial begin
        clear_inputs();

        // ---------------- Reset state ----------------
        do_reset();
        #1;
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_master_req", 32'(bus.master_req), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_master_addr", bus.master_addr, 32'd0);
        check("rst_rsp_data", bus.rsp_data, 32'd0);
        base_req = req_pulses;
        base_rsp = rsp_pulses;

        // ---------------- 1: single request ----------------
        load(0, 32'h10, 32'hA5A5_A5A5, 2'd1);
        bus.req_valid = 3'b001;
        #1;
        check("t1_ready", 32'(bus.req_ready), 32'b001);
        @(negedge clk);
        check("t1_count", 32'(fifo_count), 32'd1);
        bus.req_valid = '0;
        wait_req("t1");
        check("t1_addr", bus.master_addr, 32'h10);
        check("t1_data", bus.master_data, 32'hA5A5_A5A5);
        check("t1_sel", 32'(bus.slave_sel), 32'd1);
        host_reply("t1", 1'b1, 1'b0, 32'h1234);
        check("t1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("t1_rsp_master", 32'(bus.rsp_master), 32'd0);
        check("t1_rsp_data", bus.rsp_data, 32'h1234);
        check("t1_rsp_err", 32'(bus.rsp_err), 32'd0);
        #1;
        check("t1_req_pulses", 32'(req_pulses - base_req), 32'd1);
        check("t1_rsp_pulses", 32'(rsp_pulses - base_rsp), 32'd1);

        // ---------------- 2: round-robin, all masters valid ----------------
        do_reset();
        #1;
        for (int i = 0; i < 3; i++) load(i, 32'h100 + i, 32'h200 + i, 2'(i));
        exp_ready = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b000, 3'b000};
        exp_count = '{0, 1, 1, 2, 3, 4, 4};
        bus.req_valid = 3'b111;
        #1;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("t2_ready_%0d", k), 32'(bus.req_ready), 32'(exp_ready[k]));
            check($sformatf("t2_count_%0d", k), 32'(fifo_count), 32'(exp_count[k]));
        end
        bus.req_valid = '0;
        exp_m = '{0, 1, 2, 0, 1};
        for (int k = 0; k < 5; k++) begin
            if (k > 0) wait_req($sformatf("t2_%0d", k));
            check($sformatf("t2_addr_%0d", k), bus.master_addr, 32'h100 + 32'(exp_m[k]));
            host_reply($sformatf("t2_%0d", k), 1'b1, 1'b0, 32'h1000 + 32'(k));
            check($sformatf("t2_rsp_valid_%0d", k), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("t2_rsp_master_%0d", k), 32'(bus.rsp_master), 32'(exp_m[k]));
            check($sformatf("t2_rsp_data_%0d", k), bus.rsp_data, 32'h1000 + 32'(k));
        end
        @(negedge clk);
        check("t2_drained", 32'(fifo_count), 32'd0);

        // ---------------- 3: FIFO full with stalled host ----------------
        do_reset();
        #1;
        load(2, 32'h300, 32'h301, 2'd2);
        exp_ready = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b000};
        bus.req_valid = 3'b100;
        #1;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("t3_ready_%0d", k), 32'(bus.req_ready), 32'(exp_ready[k]));
            check($sformatf("t3_count_%0d", k), 32'(fifo_count), 32'(exp_count[k]));
        end
        host_reply("t3", 1'b1, 1'b0, 32'h3333);
        check("t3_rsp_master", 32'(bus.rsp_master), 32'd2);
        check("t3_rsp_data", bus.rsp_data, 32'h3333);
        @(negedge clk);
        check("t3_full_ready", 32'(bus.req_ready), 32'b000);
        check("t3_full_count", 32'(fifo_count), 32'd4);
        @(negedge clk);
        check("t3_after_pop_ready", 32'(bus.req_ready), 32'b100);
        check("t3_after_pop_count", 32'(fifo_count), 32'd3);
        bus.req_valid = '0;

        // ---------------- 5: reset in WAIT with 3 entries queued ----------------
        @(negedge clk);
        check("t5_wait_master_req", 32'(bus.master_req), 32'd0);
        rst_n = 1'b0;
        #1;
        base_req = req_pulses;
        base_rsp = rsp_pulses;
        check("t5_rst_count", 32'(fifo_count), 32'd0);
        check("t5_rst_master_req", 32'(bus.master_req), 32'd0);
        check("t5_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("t5_no_rsp", 32'(rsp_pulses - base_rsp), 32'd0);
        check("t5_no_req", 32'(req_pulses - base_req), 32'd0);
        check("t5_count", 32'(fifo_count), 32'd0);
        check("t5_master_addr", bus.master_addr, 32'd0);

        // ---------------- 4: retry then success, ack+err means err ----------------
        @(negedge clk);
        load(1, 32'h40, 32'h55, 2'd3);
        bus.req_valid = 3'b010;
        #1;
        base_req = req_pulses;
        check("t4a_ready", 32'(bus.req_ready), 32'b010);
        @(negedge clk);
        bus.req_valid = '0;
        wait_req("t4a1");
        check("t4a1_addr", bus.master_addr, 32'h40);
        host_reply("t4a1", 1'b1, 1'b1, 32'hDEAD);
        wait_req("t4a2");
        check("t4a2_addr", bus.master_addr, 32'h40);
        host_reply("t4a2", 1'b0, 1'b1, 32'h0);
        wait_req("t4a3");
        check("t4a3_sel", 32'(bus.slave_sel), 32'd3);
        host_reply("t4a3", 1'b1, 1'b0, 32'hBEEF);
        check("t4a_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("t4a_rsp_master", 32'(bus.rsp_master), 32'd1);
        check("t4a_rsp_data", bus.rsp_data, 32'hBEEF);
        check("t4a_rsp_err", 32'(bus.rsp_err), 32'd0);
        #1;
        check("t4a_req_pulses", 32'(req_pulses - base_req), 32'd3);

        // Retries exhausted; m0 and m2 both valid, pointer now favours m2.
        @(negedge clk);
        load(0, 32'h70, 32'h71, 2'd0);
        load(2, 32'h80, 32'h66, 2'd2);
        bus.req_valid = 3'b101;
        #1;
        base_req = req_pulses;
        check("t4b_ready", 32'(bus.req_ready), 32'b100);
        @(negedge clk);
        bus.req_valid = '0;
        wait_req("t4b1");
        host_reply("t4b1", 1'b0, 1'b1, 32'h1);
        wait_req("t4b2");
        host_reply("t4b2", 1'b0, 1'b1, 32'h2);
        wait_req("t4b3");
        host_reply("t4b3", 1'b0, 1'b1, 32'h3);
        check("t4b_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("t4b_rsp_master", 32'(bus.rsp_master), 32'd2);
        check("t4b_rsp_data", bus.rsp_data, 32'd0);
        check("t4b_rsp_err", 32'(bus.rsp_err), 32'd1);
        repeat (6) @(negedge clk);
        #1;
        check("t4b_req_pulses", 32'(req_pulses - base_req), 32'd3);
        check("t4b_count", 32'(fifo_count), 32'd0);

        // ---------------- 6: stray ack/err ignored, silent host ----------------
        do_reset();
        #1;
        base_req = req_pulses;
        base_rsp = rsp_pulses;
        bus.bus_ack    = 1'b1;
        bus.bus_err    = 1'b1;
        bus.slave_data = 32'h77;
        @(negedge clk);
        bus.bus_ack    = 1'b0;
        bus.bus_err    = 1'b0;
        bus.slave_data = '0;
        repeat (4) @(negedge clk);
        #1;
        check("t6_stray_rsp", 32'(rsp_pulses - base_rsp), 32'd0);
        check("t6_stray_req", 32'(req_pulses - base_req), 32'd0);
        load(0, 32'hC0, 32'h99, 2'd0);
        bus.req_valid = 3'b001;
        @(negedge clk);
        bus.req_valid = '0;
        wait_req("t6");
        #1;
        base_rsp = rsp_pulses;
`ifdef BUS_TIMEOUT_EN
        repeat (17) @(negedge clk);
        check("t6_tmo_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("t6_tmo_rsp_err", 32'(bus.rsp_err), 32'd1);
        check("t6_tmo_rsp_data", bus.rsp_data, 32'd0);
        check("t6_tmo_rsp_master", 32'(bus.rsp_master), 32'd0);
`else
        repeat (40) @(negedge clk);
        #1;
        check("t6_silent_rsp", 32'(rsp_pulses - base_rsp), 32'd0);
        check("t6_silent_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("t6_held_addr", bus.master_addr, 32'hC0);
`endif

        check("peak_count", 32'(max_count), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
